vc_egress_sched: RTL and testbench

//  Per-port virtual-channel (VC) scheduler that drives one port of the PCIe transaction

---
 rtl/vc_egress_sched.sv | 171 +++++++++++++++++
 tb/tb_vc_egress_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vc_egress_sched.sv
// Two-VC egress scheduler: per-VC skid buffers, pause/continue stop flags and a
// weighted round-robin merge into one tagged word per cycle, output registered.
module vc_egress_sched #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned WEIGHT0 = 2,
  parameter int unsigned WEIGHT1 = 1
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [4:0] vc0_data,
  input  logic       vc0_valid,
  output logic       vc0_ready,
  input  logic [4:0] vc1_data,
  input  logic       vc1_valid,
  output logic       vc1_ready,
  input  logic       pause_vc0,
  input  logic       continue_vc0,
  input  logic       pause_vc1,
  input  logic       continue_vc1,
  output logic [5:0] data_out,
  output logic       valid_out
);

  localparam int unsigned PW    = 5;
  localparam int unsigned OW    = PW + 1;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned RUN_W = 4;

  localparam logic [RUN_W-1:0] W0      = RUN_W'(WEIGHT0);
  localparam logic [RUN_W-1:0] W1      = RUN_W'(WEIGHT1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_VC0, ST_VC1} state_e;

  logic [PW-1:0]    mem_q [2][DEPTH];
  logic [PW-1:0]    mem_d [2][DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [2];
  logic [PTR_W-1:0] wr_ptr_d [2];
  logic [PTR_W-1:0] rd_ptr_q [2];
  logic [PTR_W-1:0] rd_ptr_d [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       stop_q, stop_d;
  logic [1:0]       ready_q, ready_d;
  state_e           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [OW-1:0]    gnt_word_q, gnt_word_d;
  logic             valid_q, valid_d;
  logic [OW-1:0]    data_q, data_d;

  logic [1:0]    in_valid, in_pause, in_cont, elig, push, pop;
  logic [PW-1:0] in_data [2];
  logic          gnt, gnt_vc;

  assign in_valid   = {vc1_valid, vc0_valid};
  assign in_pause   = {pause_vc1, pause_vc0};
  assign in_cont    = {continue_vc1, continue_vc0};
  assign in_data[0] = vc0_data;
  assign in_data[1] = vc1_data;

  assign vc0_ready = ready_q[0];
  assign vc1_ready = ready_q[1];
  assign data_out  = data_q;
  assign valid_out = valid_q;

  // Weighted round-robin arbitration from registered eligibility
  always_comb begin
    gnt     = 1'b0;
    gnt_vc  = 1'b0;
    run_d   = '0;
    state_d = ST_IDLE;
    for (int v = 0; v < 2; v++) begin
      elig[v] = (cnt_q[v] != '0) && !stop_q[v];
    end
    case (state_q)
      ST_VC0: begin
        if (elig[0] && (run_q < W0)) begin
          gnt = 1'b1; gnt_vc = 1'b0; run_d = run_q + RUN_ONE;
        end else if (elig[1] && ((run_q == W0) || !elig[0])) begin
          gnt = 1'b1; gnt_vc = 1'b1; run_d = RUN_ONE;
        end else if (elig[0]) begin
          gnt = 1'b1; gnt_vc = 1'b0; run_d = W0;
        end
      end
      ST_VC1: begin
        if (elig[1] && (run_q < W1)) begin
          gnt = 1'b1; gnt_vc = 1'b1; run_d = run_q + RUN_ONE;
        end else if (elig[0] && ((run_q == W1) || !elig[1])) begin
          gnt = 1'b1; gnt_vc = 1'b0; run_d = RUN_ONE;
        end else if (elig[1]) begin
          gnt = 1'b1; gnt_vc = 1'b1; run_d = W1;
        end
      end
      default: begin
        if (elig[0]) begin
          gnt = 1'b1; gnt_vc = 1'b0; run_d = RUN_ONE;
        end else if (elig[1]) begin
          gnt = 1'b1; gnt_vc = 1'b1; run_d = RUN_ONE;
        end
      end
    endcase
    if (gnt) begin
      state_d = gnt_vc ? ST_VC1 : ST_VC0;
    end
  end

  // Buffers, flow-control flags and the two-stage output pipeline
  always_comb begin
    mem_d = mem_q;
    for (int v = 0; v < 2; v++) begin
      push[v]     = in_valid[v] && ready_q[v];
      pop[v]      = gnt && (gnt_vc == 1'(v));
      wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(push[v]);
      rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(pop[v]);
      cnt_d[v]    = cnt_q[v] + CNT_W'(push[v]) - CNT_W'(pop[v]);
      ready_d[v]  = cnt_d[v] < CNT_MAX;
      if (push[v]) begin
        mem_d[v][wr_ptr_q[v]] = in_data[v];
      end
      if (in_pause[v]) begin
        stop_d[v] = 1'b1;
      end else if (in_cont[v]) begin
        stop_d[v] = 1'b0;
      end else begin
        stop_d[v] = stop_q[v];
      end
    end
    gnt_vld_d  = gnt;
    gnt_word_d = gnt ? {gnt_vc, mem_q[gnt_vc][rd_ptr_q[gnt_vc]]} : '0;
    valid_d    = gnt_vld_q;
    data_d     = gnt_word_q;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int v = 0; v < 2; v++) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          mem_q[v][i] <= '0;
        end
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
      end
      stop_q     <= '0;
      ready_q    <= '1;
      state_q    <= ST_IDLE;
      run_q      <= '0;
      gnt_vld_q  <= 1'b0;
      gnt_word_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      stop_q     <= stop_d;
      ready_q    <= ready_d;
      state_q    <= state_d;
      run_q      <= run_d;
      gnt_vld_q  <= gnt_vld_d;
      gnt_word_q <= gnt_word_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_vc_egress_sched.sv
// Directed bench for vc_egress_sched: ordering, WRR pattern, pause/continue,
// backpressure and asynchronous reset, with hand-computed expected outputs.
module tb_vc_egress_sched;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [4:0] vc0_data, vc1_data;
  logic       vc0_valid, vc1_valid;
  logic       vc0_ready, vc1_ready;
  logic       pause_vc0, continue_vc0, pause_vc1, continue_vc1;
  logic [5:0] data_out;
  logic       valid_out;

  int checks   = 0;
  int failures = 0;

  logic [5:0] exp_seq2 [9];
  logic [5:0] exp_seq5 [5];

  vc_egress_sched dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .vc0_data     (vc0_data),
    .vc0_valid    (vc0_valid),
    .vc0_ready    (vc0_ready),
    .vc1_data     (vc1_data),
    .vc1_valid    (vc1_valid),
    .vc1_ready    (vc1_ready),
    .pause_vc0    (pause_vc0),
    .continue_vc0 (continue_vc0),
    .pause_vc1    (pause_vc1),
    .continue_vc1 (continue_vc1),
    .data_out     (data_out),
    .valid_out    (valid_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // valid=0 implies data must be 0 as well
  task automatic chk_out(input string tag, input logic exp_v, input logic [5:0] exp_d);
    chk({tag, ".valid"}, {7'd0, valid_out}, {7'd0, exp_v});
    chk({tag, ".data"}, {2'd0, data_out}, {2'd0, exp_d});
  endtask

  initial begin
    reset_L = 1'b0;
    vc0_data = '0; vc1_data = '0; vc0_valid = 1'b0; vc1_valid = 1'b0;
    pause_vc0 = 1'b0; continue_vc0 = 1'b0; pause_vc1 = 1'b0; continue_vc1 = 1'b0;
    exp_seq2 = '{6'h10, 6'h11, 6'h28, 6'h12, 6'h13, 6'h29, 6'h2A, 6'h2B, 6'h00};
    exp_seq5 = '{6'h03, 6'h04, 6'h05, 6'h06, 6'h00};

    // Reset state
    #3;
    chk_out("rst", 1'b0, 6'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;
    tick();
    chk("rst.rdy0", {7'd0, vc0_ready}, 8'd1);
    chk("rst.rdy1", {7'd0, vc1_ready}, 8'd1);
    chk_out("rst.idle", 1'b0, 6'h00);

    // 1: three back-to-back VC0 words, latency accept+2
    vc0_valid = 1'b1; vc0_data = 5'h01;
    tick(); chk_out("t1.e1", 1'b0, 6'h00);
    vc0_data = 5'h02;
    tick(); chk_out("t1.e2", 1'b0, 6'h00);
    vc0_data = 5'h03;
    tick(); chk_out("t1.e3", 1'b1, 6'h01);
    vc0_valid = 1'b0;
    tick(); chk_out("t1.e4", 1'b1, 6'h02);
    tick(); chk_out("t1.e5", 1'b1, 6'h03);
    tick(); chk_out("t1.e6", 1'b0, 6'h00);

    // 2: both buffers full, WRR 2:1 pattern
    pause_vc0 = 1'b1; pause_vc1 = 1'b1;
    tick();
    pause_vc0 = 1'b0; pause_vc1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vc0_valid = 1'b1; vc0_data = 5'(8'h10 + i);
      vc1_valid = 1'b1; vc1_data = 5'(8'h08 + i);
      tick();
      chk_out("t2.load", 1'b0, 6'h00);
    end
    vc0_valid = 1'b0; vc1_valid = 1'b0;
    chk("t2.full0", {7'd0, vc0_ready}, 8'd0);
    chk("t2.full1", {7'd0, vc1_ready}, 8'd0);
    continue_vc0 = 1'b1; continue_vc1 = 1'b1;
    tick();
    continue_vc0 = 1'b0; continue_vc1 = 1'b0;
    chk_out("t2.c0", 1'b0, 6'h00);
    tick(); chk_out("t2.c1", 1'b0, 6'h00);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_out("t2.wrr", (i < 8), exp_seq2[i]);
    end

    // 3: pause_vc1 pulse mid-stream, then continue_vc1
    pause_vc0 = 1'b1; pause_vc1 = 1'b1;
    tick();
    pause_vc0 = 1'b0; pause_vc1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vc0_valid = 1'b1; vc0_data = 5'(8'h01 + i);
      vc1_valid = (i < 3); vc1_data = 5'(8'h05 + i);
      tick();
    end
    vc0_valid = 1'b0; vc1_valid = 1'b0;
    continue_vc0 = 1'b1; continue_vc1 = 1'b1;
    tick();
    continue_vc0 = 1'b0; continue_vc1 = 1'b0;
    tick();
    tick(); chk_out("t3.o1", 1'b1, 6'h01);
    pause_vc1 = 1'b1;
    tick(); chk_out("t3.o2", 1'b1, 6'h02);
    pause_vc1 = 1'b0;
    tick(); chk_out("t3.inflight", 1'b1, 6'h25);
    tick(); chk_out("t3.o3", 1'b1, 6'h03);
    tick(); chk_out("t3.o4", 1'b1, 6'h04);
    continue_vc1 = 1'b1;
    tick(); chk_out("t3.gap1", 1'b0, 6'h00);
    continue_vc1 = 1'b0;
    tick(); chk_out("t3.gap2", 1'b0, 6'h00);
    tick(); chk_out("t3.r1", 1'b1, 6'h26);
    tick(); chk_out("t3.r2", 1'b1, 6'h27);
    tick(); chk_out("t3.end", 1'b0, 6'h00);

    // 4: pause and continue together on VC0 -> VC0 stopped
    pause_vc0 = 1'b1; continue_vc0 = 1'b1;
    tick();
    pause_vc0 = 1'b0; continue_vc0 = 1'b0;
    vc0_valid = 1'b1; vc0_data = 5'h11;
    vc1_valid = 1'b1; vc1_data = 5'h12;
    tick();
    vc0_valid = 1'b0; vc1_valid = 1'b0;
    chk_out("t4.a", 1'b0, 6'h00);
    tick(); chk_out("t4.b", 1'b0, 6'h00);
    tick(); chk_out("t4.vc1", 1'b1, 6'h32);
    tick(); chk_out("t4.held", 1'b0, 6'h00);
    continue_vc0 = 1'b1;
    tick(); chk_out("t4.c0", 1'b0, 6'h00);
    continue_vc0 = 1'b0;
    tick(); chk_out("t4.c1", 1'b0, 6'h00);
    tick(); chk_out("t4.vc0", 1'b1, 6'h11);
    tick(); chk_out("t4.end", 1'b0, 6'h00);

    // 5: backpressure on VC0, then accept+pop on the same edge
    pause_vc0 = 1'b1;
    tick();
    pause_vc0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vc0_valid = 1'b1; vc0_data = 5'(8'h01 + i);
      tick();
      chk("t5.rdy", {7'd0, vc0_ready}, (i < 3) ? 8'd1 : 8'd0);
    end
    vc0_data = 5'h05;
    tick(); chk("t5.blocked", {7'd0, vc0_ready}, 8'd0);
    continue_vc0 = 1'b1;
    tick(); chk("t5.c0", {7'd0, vc0_ready}, 8'd0);
    continue_vc0 = 1'b0;
    tick(); chk("t5.pop", {7'd0, vc0_ready}, 8'd1);
    chk_out("t5.c1", 1'b0, 6'h00);
    tick(); chk("t5.accpop1", {7'd0, vc0_ready}, 8'd1);
    chk_out("t5.o1", 1'b1, 6'h01);
    vc0_data = 5'h06;
    tick(); chk("t5.accpop2", {7'd0, vc0_ready}, 8'd1);
    chk_out("t5.o2", 1'b1, 6'h02);
    vc0_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("t5.drain", (i < 4), exp_seq5[i]);
    end

    // 6: asynchronous reset mid-burst
    for (int i = 0; i < 4; i++) begin
      vc0_valid = 1'b1; vc0_data = 5'(8'h1A + i);
      tick();
    end
    vc0_valid = 1'b0;
    chk_out("t6.burst", 1'b1, 6'h1B);
    #2 reset_L = 1'b0;
    #1 chk_out("t6.async", 1'b0, 6'h00);
    @(negedge clk);
    reset_L = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("t6.flushed", 1'b0, 6'h00);
    end
    chk("t6.rdy0", {7'd0, vc0_ready}, 8'd1);
    chk("t6.rdy1", {7'd0, vc1_ready}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
